// File: rtl/clk_divider_pkg.sv
// Shared constants and helpers for the power-of-two clock divider.
// Holds the legal range of the division exponent and a check used at elaboration.
package clk_divider_pkg;

  localparam int SCALE_MIN = 1;
  localparam int SCALE_MAX = 31;

  function automatic bit scaleLegal(input int scale);
    return (scale >= SCALE_MIN) && (scale <= SCALE_MAX);
  endfunction

endpackage

// File: rtl/clk_divider_if.sv
// Signal bundle for a clk_divider instance: control inputs plus divided-clock outputs.
// The master side drives reset/enable; the slave side is the divider itself.
interface clk_divider_if #(
  parameter int SCALE = 8
);

  logic             reset;
  logic             enable;
  logic             divClock;
  logic             rise;
  logic             fall;
  logic [SCALE-1:0] count;

  modport master (
    output reset,
    output enable,
    input  divClock,
    input  rise,
    input  fall,
    input  count
  );

  modport slave (
    input  reset,
    input  enable,
    output divClock,
    output rise,
    output fall,
    output count
  );

endinterface

// File: rtl/clk_divider.sv
// Power-of-two clock divider: free-running phase counter whose MSB is the slow clock,
// plus registered one-cycle strobes aligned with each rising and falling slow-clock edge.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int SCALE = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic             o_clock,
  output logic             o_rise,
  output logic             o_fall,
  output logic [SCALE-1:0] o_count
);

  if (!scaleLegal(SCALE)) begin : gBadScale
    $error("clk_divider: SCALE must be in 1..31");
  end

  // Counter values one cycle before the slow clock goes high / goes low.
  localparam logic [SCALE-1:0] RISE_AT = SCALE'((64'd1 << (SCALE - 1)) - 64'd1);
  localparam logic [SCALE-1:0] FALL_AT = '1;

  logic [SCALE-1:0] cnt_q = '0;
  logic [SCALE-1:0] cnt_d;
  logic             rise_q = 1'b0;
  logic             rise_d;
  logic             fall_q = 1'b0;
  logic             fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (i_enable) begin
      cnt_d  = cnt_q + SCALE'(1);
      rise_d = (cnt_q == RISE_AT);
      fall_d = (cnt_q == FALL_AT);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_clock = cnt_q[SCALE-1];
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_clk_divider.sv
// Directed self-checking bench for clk_divider with SCALE=8 and SCALE=1 instances.
// Expected values are hand-computed from the counter phase after each step.
module tb_clk_divider;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  clk_divider_if #(.SCALE(8)) if8 ();
  clk_divider_if #(.SCALE(1)) if1 ();

  clk_divider #(.SCALE(8)) dut8 (
    .i_clock  (clock),
    .i_reset  (if8.reset),
    .i_enable (if8.enable),
    .o_clock  (if8.divClock),
    .o_rise   (if8.rise),
    .o_fall   (if8.fall),
    .o_count  (if8.count)
  );

  clk_divider #(.SCALE(1)) dut1 (
    .i_clock  (clock),
    .i_reset  (if1.reset),
    .i_enable (if1.enable),
    .o_clock  (if1.divClock),
    .o_rise   (if1.rise),
    .o_fall   (if1.fall),
    .o_count  (if1.count)
  );

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge before sampling.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Step the SCALE=8 instance until o_rise, bounded so a dead divider cannot hang the run.
  task automatic waitRise8(output int n);
    n = 0;
    do begin
      applyStimulus(1);
      n++;
    end while (!if8.rise && n < 600);
  endtask

  initial begin
    int riseCnt;
    int fallCnt;
    int highCnt;
    int bothCnt;
    int strobeCnt;
    int n;

    if8.reset  = 1'b0;
    if8.enable = 1'b0;
    if1.reset  = 1'b1;
    if1.enable = 1'b0;
    #1;
    checkOutput("powerup_count", 32'(if8.count), 32'd0);

    // Reset and enable together: reset must win.
    if8.reset  = 1'b1;
    if8.enable = 1'b1;
    applyStimulus(1);
    checkOutput("reset_count", 32'(if8.count), 32'd0);
    checkOutput("reset_clock", 32'(if8.divClock), 32'd0);
    checkOutput("reset_rise", 32'(if8.rise), 32'd0);
    checkOutput("reset_fall", 32'(if8.fall), 32'd0);

    if8.reset = 1'b0;
    applyStimulus(127);
    checkOutput("free_count127", 32'(if8.count), 32'd127);
    checkOutput("free_clock_low", 32'(if8.divClock), 32'd0);
    checkOutput("free_rise_early", 32'(if8.rise), 32'd0);
    applyStimulus(1);
    checkOutput("first_rise", 32'(if8.rise), 32'd1);
    checkOutput("first_clock_high", 32'(if8.divClock), 32'd1);
    applyStimulus(1);
    checkOutput("rise_one_cycle", 32'(if8.rise), 32'd0);
    applyStimulus(126);
    checkOutput("count255", 32'(if8.count), 32'd255);
    checkOutput("fall_early", 32'(if8.fall), 32'd0);
    applyStimulus(1);
    checkOutput("wrap_count", 32'(if8.count), 32'd0);
    checkOutput("wrap_clock", 32'(if8.divClock), 32'd0);
    checkOutput("wrap_fall", 32'(if8.fall), 32'd1);
    checkOutput("wrap_rise", 32'(if8.rise), 32'd0);
    applyStimulus(1);
    checkOutput("fall_one_cycle", 32'(if8.fall), 32'd0);

    // One full output period from count 1: one strobe of each kind, 50% duty.
    riseCnt = 0;
    fallCnt = 0;
    highCnt = 0;
    bothCnt = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1);
      riseCnt += int'(if8.rise);
      fallCnt += int'(if8.fall);
      highCnt += int'(if8.divClock);
      bothCnt += int'(if8.rise & if8.fall);
    end
    checkOutput("period_rises", 32'(riseCnt), 32'd1);
    checkOutput("period_falls", 32'(fallCnt), 32'd1);
    checkOutput("period_high", 32'(highCnt), 32'd128);
    checkOutput("period_both", 32'(bothCnt), 32'd0);
    checkOutput("period_count", 32'(if8.count), 32'd1);

    // Enable gap at phase 100: everything holds, then resume from the same phase.
    applyStimulus(99);
    checkOutput("gap_start", 32'(if8.count), 32'd100);
    if8.enable = 1'b0;
    strobeCnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      strobeCnt += int'(if8.rise) + int'(if8.fall);
    end
    checkOutput("gap_hold", 32'(if8.count), 32'd100);
    checkOutput("gap_strobes", 32'(strobeCnt), 32'd0);
    if8.enable = 1'b1;
    waitRise8(n);
    checkOutput("gap_rise_delay", 32'(n), 32'd28);

    // Mid-run reset with the slow clock high.
    applyStimulus(72);
    checkOutput("mid_count", 32'(if8.count), 32'd200);
    checkOutput("mid_clock", 32'(if8.divClock), 32'd1);
    if8.reset = 1'b1;
    applyStimulus(1);
    checkOutput("mid_reset_count", 32'(if8.count), 32'd0);
    checkOutput("mid_reset_clock", 32'(if8.divClock), 32'd0);
    if8.reset = 1'b0;
    waitRise8(n);
    checkOutput("mid_rise_delay", 32'(n), 32'd128);

    // Enable dropped exactly where a rise strobe would have been produced.
    if8.reset = 1'b1;
    applyStimulus(1);
    if8.reset = 1'b0;
    applyStimulus(127);
    if8.enable = 1'b0;
    applyStimulus(1);
    checkOutput("hold_count127", 32'(if8.count), 32'd127);
    checkOutput("hold_no_rise", 32'(if8.rise), 32'd0);
    if8.enable = 1'b1;
    applyStimulus(1);
    checkOutput("resume_rise", 32'(if8.rise), 32'd1);
    checkOutput("resume_count", 32'(if8.count), 32'd128);

    // SCALE=1: output is clock/2 with alternating strobes.
    if1.enable = 1'b1;
    applyStimulus(1);
    checkOutput("s1_reset_count", 32'(if1.count), 32'd0);
    if1.reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1);
      checkOutput("s1_clock", 32'(if1.divClock), 32'(k % 2));
      checkOutput("s1_rise", 32'(if1.rise), 32'(k % 2));
      checkOutput("s1_fall", 32'(if1.fall), 32'((k + 1) % 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
